multiplicador_seq_param: RTL and testbench
==========================================

# multiplicador_seq_param

- Parametrised sequential shift-add multiplier for the RPN ALU. It replaces the fixed 8-bit counter/decoder pair with a single block of generic operand width. The block contains its own step counter, the decoded phase strobes, the datapath, a start/busy/done handshake and an optional signed (two's-complement) mode.
- It sits between the RPN operand stack and the result multiplexer, as the ALU's multiply operator.

## Interface
Parameters:
- WIDTH, 8: operand width in bits, ≥ 2. The product is 2·WIDTH bits wide.
- SIGNED_EN, 1: when 0, `signed_mode` is ignored and all operations are unsigned.
- CNT_W (localparam): clog2(WIDTH+2), the width of the step counter.

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to multiply; sampled only in the LOAD phase.
- signed_mode  in  1  1 = treat `a` and `b` as two's complement; sampled with `start`.
- a  in  WIDTH  multiplicand; sampled with `start`.
- b  in  WIDTH  multiplier; sampled with `start`.
- product  out  2·WIDTH  result; two's complement when the operation was signed.
- busy  out  1  high whenever the block is not in LOAD.
- load_signal  out  1  phase strobe, count = 0.
- calc_signal  out  1  phase strobe, 1 ≤ count ≤ WIDTH.
- done_signal  out  1  phase strobe, count = WIDTH+1; one-cycle completion pulse.
- count  out  CNT_W  current step counter value.

## Operation
- The step counter runs 0 → 1 → … → WIDTH → WIDTH+1 → 0. The three phases are decoded from it:
  - LOAD = 0
  - CALC = 1..WIDTH
  - DONE = WIDTH+1
- Exactly one strobe is high in every cycle. Counter values above WIDTH+1 are unreachable.
- In LOAD with `start` = 1:
  - With `sgn = signed_mode & SIGNED_EN`, latch `M = sgn ? |a| : a` and `Q = sgn ? |b| : b`.
  - Latch the sign flag `S = sgn & (a[W-1] ^ b[W-1])`.
  - Clear the accumulator `H` (WIDTH bits) and the carry bit `C`.
  - Set count to 1.
- In LOAD with `start` = 0: hold all state.
- |−2^(W−1)| = 2^(W−1) is handled as an unsigned WIDTH-bit value; no overflow is possible.
- In each CALC cycle:
  - `{C,H} = H + (Q[0] ? M : 0)`, computed at WIDTH+1 bits.
  - Then shift `{C,H,Q}` right by 1, with `C` cleared afterwards.
  - Increment count.
- After WIDTH CALC cycles, `{H,Q}` holds the unsigned magnitude P.
- `product = S ? −P : P`, computed combinationally from the registers at 2·WIDTH bits.
  - It is valid from the DONE cycle until the edge that accepts the next `start`.
  - At that edge it becomes undefined until the next DONE. The bench checks it only while `done_signal` = 1 or in LOAD after a DONE.
- In DONE: count returns to 0 on the next edge. `start` is ignored in DONE.
- `start` during CALC or DONE is ignored. `a`, `b` and `signed_mode` changes after acceptance have no effect.
- Reset values (the cycle after `rst` is sampled high):
  - count = 0, M = Q = H = 0, C = 0, S = 0, product = 0.
  - load_signal = 1, calc_signal = 0, done_signal = 0, busy = 0.
- `rst` takes priority over `start` and over any phase, including mid-CALC. An aborted operation never produces `done_signal`.

## Timing
- `start` sampled at edge E0: count = 1 after E0, count = WIDTH+1 after edge E0+WIDTH.
- `done_signal` is high for exactly one cycle, WIDTH+1 cycles after the accepting edge.
- The next `start` can be accepted at edge E0+WIDTH+2, so the back-to-back period is WIDTH+2 cycles. For WIDTH = 8 that is 10 cycles: count 0..9.
- The critical path is one WIDTH+1-bit add plus the 2·WIDTH-bit output negation. No multi-cycle paths.

## Test plan
- **Unsigned full scale:** WIDTH=8, a=0xFF, b=0xFF, signed_mode=0, start pulse → done_signal high exactly 9 cycles later, product = 0xFE01; count sequence 1..9 then 0.
- **Signed corners:** WIDTH=8, signed_mode=1:
  - −128·−128 → 0x4000
  - −3·5 → 0xFFF1
  - 127·−128 → 0xC080
  - 0·−1 → 0x0000
  - With SIGNED_EN=0, −3·5 → 253·5 = 0x04F1.
- **Back-to-back:** start held high continuously with a=7, b=9 → done pulses every 10 cycles, product = 63 each time; strobes one-hot every cycle; start ignored while busy.
- **Abort:** rst asserted when count=4 → next cycle count=0, load_signal=1, product=0, busy=0; no done_signal for the aborted operation; a following start 6·7 → product = 42.
- **Operand stability:** change a/b/signed_mode mid-CALC → result still reflects the values sampled with start.
- **WIDTH=4 instance:** 15·15 unsigned → 0xE1 after 5 cycles; −8·−8 signed → 0x40; −8·7 → 0xC8.

Source files
------------

// File: rtl/multiplicador_seq_param.sv
// Sequential shift-add multiplier with generic operand width and optional
// two's-complement mode; one product every WIDTH+2 cycles.
module multiplicador_seq_param #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1,
  localparam int CNT_W    = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 load_signal,
  output logic                 calc_signal,
  output logic                 done_signal,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH + 1);
  localparam bit               SGN_EN   = (SIGNED_EN != 0);

  // Magnitude of a two's-complement operand; the most negative value maps
  // onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_p(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             s_q, s_d;
  logic [WIDTH:0]   sum;
  logic             sgn;

  assign load_signal = (count_q == '0);
  assign done_signal = (count_q == CNT_DONE);
  assign calc_signal = !load_signal && !done_signal;
  assign busy        = !load_signal;
  assign count       = count_q;

  always_comb begin
    count_d = count_q;
    m_d     = m_q;
    q_d     = q_q;
    h_d     = h_q;
    s_d     = s_q;
    sum     = '0;
    sgn     = signed_mode & SGN_EN;
    if (load_signal) begin
      if (start) begin
        m_d     = sgn ? abs_w(a) : a;
        q_d     = sgn ? abs_w(b) : b;
        s_d     = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        h_d     = '0;
        count_d = CNT_W'(1);
      end
    end else if (calc_signal) begin
      // Carry of the add drops straight into H's MSB during the shift.
      sum     = {1'b0, h_q} + {1'b0, (q_q[0] ? m_q : '0)};
      h_d     = sum[WIDTH:1];
      q_d     = {sum[0], q_q[WIDTH-1:1]};
      count_d = count_q + 1'b1;
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      m_q     <= '0;
      q_q     <= '0;
      h_q     <= '0;
      s_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      m_q     <= m_d;
      q_q     <= q_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end

  assign product = s_q ? neg_p({h_q, q_q}) : {h_q, q_q};

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Directed bench: three instances (8-bit signed-capable, 8-bit unsigned-only,
// 4-bit signed-capable) sharing clock, reset, start and signed_mode.
module tb_multiplicador_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sm;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;

  logic [15:0] product8, product8u;
  logic        busy8, load8, calc8, done8;
  logic        busy8u, load8u, calc8u, done8u;
  logic [3:0]  count8, count8u;
  logic [7:0]  product4;
  logic        busy4, load4, calc4, done4;
  logic [2:0]  count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiplicador_seq_param #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a8), .b(b8),
    .product(product8), .busy(busy8), .load_signal(load8), .calc_signal(calc8),
    .done_signal(done8), .count(count8)
  );

  multiplicador_seq_param #(.WIDTH(8), .SIGNED_EN(0)) u_dut8u (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a8), .b(b8),
    .product(product8u), .busy(busy8u), .load_signal(load8u), .calc_signal(calc8u),
    .done_signal(done8u), .count(count8u)
  );

  multiplicador_seq_param #(.WIDTH(4), .SIGNED_EN(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a4), .b(b4),
    .product(product4), .busy(busy4), .load_signal(load4), .calc_signal(calc4),
    .done_signal(done4), .count(count4)
  );

  // Starts one operation on all three instances from LOAD and follows it
  // cycle by cycle until the 8-bit instances are back in LOAD.
  task automatic run_mul(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic [3:0] a4v, input logic [3:0] b4v, input logic smv,
                         input logic [15:0] e8, input logic [15:0] eu, input logic [7:0] e4,
                         input bit scramble);
    logic [3:0] ce8;
    logic [2:0] ce4;
    logic [2:0] strb;
    a8 = av; b8 = bv; a4 = a4v; b4 = b4v; sm = smv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      ce8  = (k <= 9) ? 4'(k) : 4'd0;
      ce4  = (k <= 5) ? 3'(k) : 3'd0;
      strb = (k == 10) ? 3'b100 : (k == 9) ? 3'b001 : 3'b010;
      total++;
      if (count8 !== ce8) begin
        bad++; $display("FAIL %s count8 k=%0d: got %0d expected %0d", name, k, count8, ce8);
      end
      total++;
      if ({load8, calc8, done8} !== strb) begin
        bad++; $display("FAIL %s strobes k=%0d: got %b expected %b", name, k, {load8, calc8, done8}, strb);
      end
      total++;
      if (busy8 !== (k != 10)) begin
        bad++; $display("FAIL %s busy8 k=%0d: got %b expected %b", name, k, busy8, (k != 10));
      end
      total++;
      if (done8u !== (k == 9)) begin
        bad++; $display("FAIL %s done8u k=%0d: got %b expected %b", name, k, done8u, (k == 9));
      end
      total++;
      if (count4 !== ce4 || done4 !== (k == 5)) begin
        bad++; $display("FAIL %s w4 count/done k=%0d: got %0d/%b expected %0d/%b", name, k, count4, done4, ce4, (k == 5));
      end
      if (k >= 9) begin
        total++;
        if (product8 !== e8) begin
          bad++; $display("FAIL %s product8 k=%0d: got %h expected %h", name, k, product8, e8);
        end
        total++;
        if (product8u !== eu) begin
          bad++; $display("FAIL %s product8u k=%0d: got %h expected %h", name, k, product8u, eu);
        end
      end
      if (k == 5 || k == 10) begin
        total++;
        if (product4 !== e4) begin
          bad++; $display("FAIL %s product4 k=%0d: got %h expected %h", name, k, product4, e4);
        end
      end
      if (scramble && k == 3) begin
        a8 = 8'h11; b8 = 8'h22; a4 = 4'h5; b4 = 4'h6; sm = ~sm; start = 1'b1;
      end
      if (k < 10) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sm = 1'b0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if ({count8, load8, calc8, done8, busy8, product8} !== {4'd0, 4'b1000, 16'h0}) begin
      bad++; $display("FAIL reset dut8: got cnt=%0d l/c/d/b=%b%b%b%b p=%h expected 0 1000 0000",
                      count8, load8, calc8, done8, busy8, product8);
    end
    total++;
    if ({count8u, load8u, calc8u, done8u, busy8u, product8u} !== {4'd0, 4'b1000, 16'h0}) begin
      bad++; $display("FAIL reset dut8u: got cnt=%0d l/c/d/b=%b%b%b%b p=%h expected 0 1000 0000",
                      count8u, load8u, calc8u, done8u, busy8u, product8u);
    end
    total++;
    if ({count4, load4, calc4, done4, busy4, product4} !== {3'd0, 4'b1000, 8'h0}) begin
      bad++; $display("FAIL reset dut4: got cnt=%0d l/c/d/b=%b%b%b%b p=%h expected 0 1000 00",
                      count4, load4, calc4, done4, busy4, product4);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (count8 !== 4'd0 || product8 !== 16'h0) begin
      bad++; $display("FAIL idle_hold: got cnt=%0d p=%h expected 0 0000", count8, product8);
    end
  endtask

  task automatic test_unsigned_full();
    run_mul("full_scale", 8'hFF, 8'hFF, 4'hF, 4'hF, 1'b0, 16'hFE01, 16'hFE01, 8'hE1, 1'b0);
  endtask

  task automatic test_signed_corners();
    run_mul("neg128_sq", 8'h80, 8'h80, 4'h8, 4'h8, 1'b1, 16'h4000, 16'h4000, 8'h40, 1'b0);
    run_mul("m3_x_5",    8'hFD, 8'h05, 4'h8, 4'h7, 1'b1, 16'hFFF1, 16'h04F1, 8'hC8, 1'b0);
    run_mul("127_x_m128", 8'h7F, 8'h80, 4'h7, 4'h7, 1'b1, 16'hC080, 16'h3F80, 8'h31, 1'b0);
    run_mul("0_x_m1",    8'h00, 8'hFF, 4'hF, 4'h1, 1'b1, 16'h0000, 16'h0000, 8'hFF, 1'b0);
  endtask

  task automatic test_operand_stability();
    run_mul("stability", 8'hFD, 8'h05, 4'h3, 4'hD, 1'b1, 16'hFFF1, 16'h04F1, 8'hF7, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev, ce;
    int ndone, last_done;
    ndone = 0; last_done = 0; prev = count8;
    a8 = 8'd7; b8 = 8'd9; sm = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(posedge clk); #1;
      ce = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
      total++;
      if (count8 !== ce || (32'(load8) + 32'(calc8) + 32'(done8)) != 1) begin
        bad++; $display("FAIL b2b cyc=%0d: got cnt=%0d l/c/d=%b%b%b expected cnt=%0d one-hot",
                        cyc, count8, load8, calc8, done8, ce);
      end
      if (done8 === 1'b1 || (load8 === 1'b1 && ndone > 0)) begin
        total++;
        if (product8 !== 16'd63) begin
          bad++; $display("FAIL b2b product cyc=%0d: got %0d expected 63", cyc, product8);
        end
      end
      if (done8 === 1'b1) begin
        if (last_done > 0) begin
          total++;
          if (cyc - last_done != 10) begin
            bad++; $display("FAIL b2b period: got %0d expected 10", cyc - last_done);
          end
        end
        last_done = cyc;
        ndone++;
      end
      prev = count8;
    end
    total++;
    if (ndone != 3) begin
      bad++; $display("FAIL b2b done_count: got %0d expected 3", ndone);
    end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    a8 = 8'd200; b8 = 8'd3; a4 = 4'd5; b4 = 4'd3; sm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8 && count8 !== 4'd4; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (count8 !== 4'd4) begin
      bad++; $display("FAIL abort reach_count4: got %0d expected 4", count8);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({count8, load8, busy8, product8} !== {4'd0, 1'b1, 1'b0, 16'h0}) begin
      bad++; $display("FAIL abort state: got cnt=%0d load=%b busy=%b p=%h expected 0 1 0 0000",
                      count8, load8, busy8, product8);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL abort no_done: got done pulse expected none");
    end
    run_mul("abort_follow", 8'd6, 8'd7, 4'd6, 4'd2, 1'b0, 16'h002A, 16'h002A, 8'h0C, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned_full();
    test_signed_corners();
    test_operand_stability();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
